// File: rtl/mmc6_wram_arb.sv
// MMC6 1 KB work-RAM sequencer: CPU accesses are served while M2 is high, and a
// backup (save-state) port borrows the start of each M2-low gap without protection checks.
module mmc6_wram_arb #(
    parameter int GUARD       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_m2,
    input  logic        i_cpu_rw,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_data,
    input  logic        i_ram_en,
    input  logic [3:0]  i_prot,
    input  logic        i_bkp_req,
    input  logic        i_bkp_wr,
    input  logic [9:0]  i_bkp_addr,
    input  logic [7:0]  i_bkp_wdat,
    output logic        o_bkp_ack,
    output logic [7:0]  o_bkp_rdat,
    output logic        o_mem_ce,
    output logic        o_mem_oe,
    output logic        o_mem_we,
    output logic [9:0]  o_mem_addr,
    output logic [7:0]  o_mem_di,
    input  logic [7:0]  i_mem_do,
    output logic        o_cpu_oe,
    output logic [7:0]  o_cpu_do
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CPU    = 3'd1,
        ST_B_SET  = 3'd2,
        ST_B_ACC  = 3'd3,
        ST_B_DONE = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_m2_sync;
    logic                   r_m2_d;
    logic [7:0]             r_low_cnt;
    logic                   r_cpu_late;
    logic [7:0]             r_bkp_rdat;

    logic w_m2_s;
    logic w_rise;
    logic w_fall;
    logic w_area;
    logic w_half;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_bkp_go;
    logic w_unused;

    // Read enable of the half selected by A9.
    function automatic logic f_rd_ok(input logic en, input logic [3:0] p, input logic half);
        return en & (half ? p[3] : p[1]);
    endfunction

    // Writing additionally requires the half to be readable (enabled).
    function automatic logic f_wr_ok(input logic en, input logic [3:0] p, input logic half);
        return en & (half ? (p[2] & p[3]) : (p[0] & p[1]));
    endfunction

    assign w_m2_s   = r_m2_sync[SYNC_STAGES-1];
    assign w_rise   = w_m2_s & ~r_m2_d;
    assign w_fall   = ~w_m2_s & r_m2_d;
    assign w_area   = (i_cpu_addr[15:12] == 4'h7);
    assign w_half   = i_cpu_addr[9];
    assign w_rd_ok  = f_rd_ok(i_ram_en, i_prot, w_half);
    assign w_wr_ok  = f_wr_ok(i_ram_en, i_prot, w_half);
    assign w_bkp_go = i_bkp_req & ~w_m2_s & ~w_rise & (r_low_cnt < 8'(GUARD));
    assign w_unused = ^i_cpu_addr[11:10];

    assign o_bkp_rdat = r_bkp_rdat;

    // Next-state selection; an M2 rise always pre-empts an unfinished backup access.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && w_area) begin
                    w_next = ST_CPU;
                end else if (w_bkp_go) begin
                    w_next = ST_B_SET;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CPU: begin
                if (!w_m2_s) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_CPU;
                end
            end
            ST_B_SET: begin
                if (w_rise) begin
                    w_next = w_area ? ST_CPU : ST_IDLE;
                end else begin
                    w_next = ST_B_ACC;
                end
            end
            ST_B_ACC: begin
                if (w_rise) begin
                    w_next = w_area ? ST_CPU : ST_IDLE;
                end else begin
                    w_next = ST_B_DONE;
                end
            end
            ST_B_DONE: begin
                if (w_rise && w_area) begin
                    w_next = ST_CPU;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Memory and CPU-bus drives decoded from state; protection bits act immediately.
    always_comb begin
        o_mem_ce   = 1'b0;
        o_mem_oe   = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = 10'd0;
        o_mem_di   = 8'h00;
        o_cpu_oe   = 1'b0;
        o_cpu_do   = 8'h00;
        o_bkp_ack  = 1'b0;
        case (r_state)
            ST_CPU: begin
                o_mem_addr = i_cpu_addr[9:0];
                if (i_cpu_rw) begin
                    o_mem_ce = w_rd_ok;
                    o_mem_oe = w_rd_ok;
                    o_cpu_oe = 1'b1;
                    o_cpu_do = w_rd_ok ? i_mem_do : 8'h00;
                end else begin
                    o_mem_ce = w_wr_ok;
                    o_mem_di = i_cpu_data;
                    o_mem_we = w_wr_ok & r_cpu_late;
                end
            end
            ST_B_SET, ST_B_ACC: begin
                o_mem_ce   = 1'b1;
                o_mem_addr = i_bkp_addr;
                o_mem_oe   = ~i_bkp_wr;
                o_mem_di   = i_bkp_wdat;
                o_mem_we   = i_bkp_wr;
            end
            ST_B_DONE: o_bkp_ack = 1'b1;
            default:   o_bkp_ack = 1'b0;
        endcase
    end

    // State, M2 synchroniser, gap counter and backup read capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_m2_sync  <= {SYNC_STAGES{1'b0}};
            r_m2_d     <= 1'b0;
            r_low_cnt  <= 8'hFF;
            r_cpu_late <= 1'b0;
            r_bkp_rdat <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_m2_sync  <= {r_m2_sync[SYNC_STAGES-2:0], i_cpu_m2};
            r_m2_d     <= w_m2_s;
            r_cpu_late <= (r_state == ST_CPU) && (w_next == ST_CPU);
            if (w_fall) begin
                r_low_cnt <= 8'd0;
            end else if (!w_m2_s && (r_low_cnt != 8'hFF)) begin
                r_low_cnt <= r_low_cnt + 8'd1;
            end else begin
                r_low_cnt <= r_low_cnt;
            end
            // Only a completed (non-aborted) read updates the visible read data.
            if ((r_state == ST_B_ACC) && (w_next == ST_B_DONE) && !i_bkp_wr) begin
                r_bkp_rdat <= i_mem_do;
            end else begin
                r_bkp_rdat <= r_bkp_rdat;
            end
        end
    end

endmodule

// File: tb/tb_mmc6_wram_arb.sv
// Directed bench for mmc6_wram_arb with a behavioural WRAM and a backup-read scoreboard.
module tb_mmc6_wram_arb;

    logic        clk = 1'b0;
    logic        rst_n, cpu_m2, cpu_rw, ram_en, bkp_req, bkp_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data, bkp_wdat, mem_do, bkp_rdat, mem_di, cpu_do;
    logic [3:0]  prot;
    logic [9:0]  bkp_addr, mem_addr;
    logic        bkp_ack, mem_ce, mem_oe, mem_we, cpu_oe;

    logic [7:0]  mem [0:1023];
    logic [7:0]  bkp_q [$];
    logic [7:0]  cpu_q [$];
    int          n_pass = 0, n_fail = 0, n_total = 0, ack_cnt = 0;
    int          lat, a0;
    logic        we_seen = 1'b0;
    logic        s_ce1, s_we1, s_we2, s_ce, s_oe, s_cpu_oe;
    logic [7:0]  s_cpu_do;

    mmc6_wram_arb #(.GUARD(8), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_m2(cpu_m2), .i_cpu_rw(cpu_rw),
        .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data), .i_ram_en(ram_en), .i_prot(prot),
        .i_bkp_req(bkp_req), .i_bkp_wr(bkp_wr), .i_bkp_addr(bkp_addr), .i_bkp_wdat(bkp_wdat),
        .o_bkp_ack(bkp_ack), .o_bkp_rdat(bkp_rdat), .o_mem_ce(mem_ce), .o_mem_oe(mem_oe),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_di(mem_di), .i_mem_do(mem_do),
        .o_cpu_oe(cpu_oe), .o_cpu_do(cpu_do)
    );

    always #5 clk = ~clk;

    // WRAM model: synchronous write, read data one clock after ce/oe.
    always @(posedge clk) begin
        if (mem_ce && mem_we) mem[mem_addr] <= mem_di;
        if (mem_ce && mem_oe) mem_do <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ack monitor: every ack pops the oldest expected backup read byte.
    always @(negedge clk) begin
        if (mem_we) we_seen = 1'b1;
        if (bkp_ack) begin
            ack_cnt++;
            if (bkp_q.size() == 0) check("bkp_unexpected_ack", 64'(bkp_ack), 64'd0);
            else check("bkp_rdat", 64'(bkp_rdat), 64'(bkp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string tag);
        check(tag, 64'({bkp_ack, mem_ce, mem_oe, mem_we, cpu_oe, mem_addr, mem_di, cpu_do, bkp_rdat}),
              64'd0);
    endtask

    // One M2-high phase of 8 clocks; returns at the negedge where M2 is lowered.
    task automatic m2_high(input logic rw, input logic [15:0] addr, input logic [7:0] data);
        cpu_rw = rw; cpu_addr = addr; cpu_data = data; cpu_m2 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin s_ce1 = mem_ce; s_we1 = mem_we; end
            if (k == 4) s_we2 = mem_we;
            if (k == 8) begin
                s_ce = mem_ce; s_oe = mem_oe; s_cpu_oe = cpu_oe; s_cpu_do = cpu_do;
            end
        end
        cpu_m2 = 1'b0;
    endtask

    task automatic bkp_start(input logic wr, input logic [9:0] addr, input logic [7:0] wdat);
        bkp_wr = wr; bkp_addr = addr; bkp_wdat = wdat; bkp_req = 1'b1;
    endtask

    task automatic wait_ack(input int max, output int l);
        l = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bkp_ack) begin l = i; break; end
        end
        bkp_req = 1'b0; bkp_wr = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] addr);
        m2_high(1'b1, addr, 8'h00);
        check({tag, "_oe"}, 64'(s_cpu_oe), 64'd1);
        check({tag, "_do"}, 64'(s_cpu_do), 64'(cpu_q.pop_front()));
        tick(12);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cpu_m2 = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0000; cpu_data = 8'h00;
        ram_en = 1'b1; prot = 4'b0011;
        bkp_req = 1'b0; bkp_wr = 1'b0; bkp_addr = 10'd0; bkp_wdat = 8'h00;
        tick(4);
        check_outs("reset_outs");
        rst_n = 1'b1;
        tick(2);
        check_outs("idle_outs");

        // Low-half write then read back, plus a mirror alias.
        m2_high(1'b0, 16'h7005, 8'h5A);
        check("t1_ce_clk1", 64'(s_ce1), 64'd1);
        check("t1_we_clk1", 64'(s_we1), 64'd0);
        check("t1_we_clk2", 64'(s_we2), 64'd1);
        tick(12);
        m2_high(1'b0, 16'h7001, 8'h3C); tick(12);
        m2_high(1'b0, 16'h71FF, 8'hC3); tick(12);
        cpu_q.push_back(8'h5A); cpu_read("t1_rd", 16'h7005);
        cpu_q.push_back(8'h5A); cpu_read("t1_mirror", 16'h7405);

        // High half disabled: write suppressed, read returns zero without a RAM cycle.
        we_seen = 1'b0;
        m2_high(1'b0, 16'h7205, 8'h77); tick(12);
        check("t2_no_we", 64'(we_seen), 64'd0);
        cpu_q.push_back(8'h00); cpu_read("t2_rd", 16'h7205);
        check("t2_ce", 64'(s_ce), 64'd0);
        prot = 4'hF;
        m2_high(1'b0, 16'h7205, 8'h77); tick(12);
        cpu_q.push_back(8'h77); cpu_read("t2_hi_en", 16'h7205);

        // Global disable overrides prot.
        ram_en = 1'b0;
        cpu_q.push_back(8'h00); cpu_read("t3_rd", 16'h7005);
        check("t3_ce", 64'(s_ce), 64'd0);
        ram_en = 1'b1; prot = 4'b0011;
        m2_high(1'b1, 16'h6005, 8'h00);
        check("na_cpu_oe", 64'({s_cpu_oe, s_ce}), 64'd0);
        tick(12);

        // Backup read mid-gap (low_cnt=2): ack 3 clocks later.
        m2_high(1'b1, 16'h8000, 8'h00); tick(5);
        bkp_start(1'b0, 10'h1FF, 8'h00); bkp_q.push_back(8'hC3);
        wait_ack(20, lat);
        check("t4_latency", 64'(lat), 64'd3);
        tick(1);
        check("t4_sb_empty", 64'(bkp_q.size()), 64'd0);
        tick(10);

        // Request at low_cnt=GUARD waits for the next gap.
        m2_high(1'b1, 16'h8000, 8'h00); tick(11);
        bkp_start(1'b0, 10'h005, 8'h00); bkp_q.push_back(8'h5A);
        a0 = ack_cnt;
        tick(6);
        check("t4_guard_noack", 64'(ack_cnt), 64'(a0));
        m2_high(1'b1, 16'h8000, 8'h00);
        check("t4_guard_noack_hi", 64'(ack_cnt), 64'(a0));
        wait_ack(20, lat);
        check("t4_guard_latency", 64'(lat), 64'd6);
        tick(1);
        check("t4_guard_sb", 64'(bkp_q.size()), 64'd0);
        tick(10);

        // M2 rise during B_ACC aborts the backup; CPU read wins, backup retries.
        m2_high(1'b1, 16'h8000, 8'h00); tick(5);
        bkp_start(1'b0, 10'h005, 8'h00); bkp_q.push_back(8'h5A);
        a0 = ack_cnt;
        m2_high(1'b1, 16'h7001, 8'h00);
        check("t5_cpu_do", 64'(s_cpu_do), 64'h3C);
        check("t5_abort_noack", 64'(ack_cnt), 64'(a0));
        wait_ack(20, lat);
        check("t5_retry_latency", 64'(lat), 64'd6);
        tick(1);
        check("t5_sb_empty", 64'(bkp_q.size()), 64'd0);
        tick(10);

        // Reset during B_ACC: outputs clear, request waits for an M2 fall.
        m2_high(1'b1, 16'h8000, 8'h00); tick(5);
        bkp_start(1'b0, 10'h1FF, 8'h00); bkp_q.push_back(8'hC3);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check_outs("t6_reset_outs");
        rst_n = 1'b1;
        a0 = ack_cnt;
        tick(10);
        check("t6_no_ack_before_fall", 64'(ack_cnt), 64'(a0));
        m2_high(1'b1, 16'h8000, 8'h00);
        wait_ack(20, lat);
        check("t6_latency", 64'(lat), 64'd6);
        tick(1);
        check("t6_sb_empty", 64'(bkp_q.size()), 64'd0);
        tick(10);

        // Backup write bypasses disable; write ack keeps previous read data.
        ram_en = 1'b0; prot = 4'h0;
        m2_high(1'b1, 16'h8000, 8'h00); tick(5);
        bkp_start(1'b1, 10'h2AA, 8'hE1); bkp_q.push_back(8'hC3);
        wait_ack(20, lat);
        check("t7_wr_latency", 64'(lat), 64'd3);
        tick(10);
        m2_high(1'b1, 16'h8000, 8'h00); tick(5);
        bkp_start(1'b0, 10'h2AA, 8'h00); bkp_q.push_back(8'hE1);
        wait_ack(20, lat);
        check("t7_rd_latency", 64'(lat), 64'd3);
        tick(10);
        ram_en = 1'b1; prot = 4'hF;
        cpu_q.push_back(8'hE1); cpu_read("t7_cpu", 16'h72AA);
        check("t7_sb_empty", 64'(bkp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
